// File: rtl/serial_addsub32_pkg.sv
// Shared constants and state encoding for the byte-serial 32-bit add/subtract unit.
// WIDTH must be a whole multiple of SLICE.
package serial_addsub32_pkg;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = $clog2(NSLICE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_addsub32_if.sv
// Operand/result handshake bundle between producer, unit and consumer.
interface serial_addsub32_if;
    import serial_addsub32_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, y, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, y, cout, ovf
    );

endinterface

// File: rtl/serial_addsub32_slice.sv
// One SLICE-bit add/subtract step; the extra top bit of the result is carry (add) or borrow (sub).
module addsub_slice
    import serial_addsub32_pkg::*;
(
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] yv,
    input  logic             cin,
    input  logic             sub,
    output logic [SLICE-1:0] s,
    output logic             co
);

    logic [SLICE:0] ext;

    // Subtraction underflow sets the top bit, which is exactly the borrow out.
    always_comb begin
        ext = '0;
        if (sub)
            ext = {1'b0, x} - {1'b0, yv} - {{SLICE{1'b0}}, cin};
        else
            ext = {1'b0, x} + {1'b0, yv} + {{SLICE{1'b0}}, cin};
    end

    assign s  = ext[SLICE-1:0];
    assign co = ext[SLICE];

endmodule

// File: rtl/serial_addsub32.sv
// Byte-serial 32-bit add/subtract: one slice per clock through a single carry/borrow register.
// States: IDLE accepts operands, BUSY walks slices 0..NSLICE-1, DONE holds result until taken.
module serial_addsub32
    import serial_addsub32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    serial_addsub32_if.slave  bus
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q, b_q, y_q;
    logic             sub_q, c_q, cout_q, ovf_q;

    logic [SLICE-1:0] x_sl, yv_sl, s_sl;
    logic             co_sl, last, a_msb, b_msb, ovf_d;

    assign x_sl  = a_q[idx_q*SLICE +: SLICE];
    assign yv_sl = b_q[idx_q*SLICE +: SLICE];
    assign last  = (idx_q == IDX_W'(NSLICE-1));
    assign a_msb = a_q[WIDTH-1];
    assign b_msb = b_q[WIDTH-1];
    assign ovf_d = sub_q ? ((a_msb != b_msb) && (s_sl[SLICE-1] != a_msb))
                         : ((a_msb == b_msb) && (s_sl[SLICE-1] != a_msb));

    addsub_slice u_slice (
        .x   (x_sl),
        .yv  (yv_sl),
        .cin (c_q),
        .sub (sub_q),
        .s   (s_sl),
        .co  (co_sl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = BUSY;
            BUSY:    if (last)         state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            c_q     <= 1'b0;
            y_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        sub_q <= bus.sub;
                        c_q   <= 1'b0;
                        idx_q <= '0;
                        y_q   <= '0;
                    end
                end
                BUSY: begin
                    y_q[idx_q*SLICE +: SLICE] <= s_sl;
                    c_q   <= co_sl;
                    idx_q <= idx_q + IDX_W'(1);
                    if (last) begin
                        cout_q <= co_sl;
                        ovf_q  <= ovf_d;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshake flags decode registered state only; no path from out_ready to in_ready.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.y         = y_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule
